// File: rtl/axi_lite_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_rd_arbiter
//
// Shares one AXI-lite read port between the instruction fetch unit (IFU) and
// the load/store unit (LSU). The AR channel is arbitrated round-robin. An
// in-order owner FIFO records which master issued each accepted address, and
// the head of that FIFO steers each R beat back to that master.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ifu_ar*/ifu_r*        IFU read address / read data channels (slave side)
//   lsu_ar*/lsu_r*        LSU read address / read data channels (slave side)
//   m_ar*/m_r*            downstream read address / read data (master side)
//   ost_cnt               number of accepted reads still waiting for data
//   rsp_err               sticky: an R beat arrived with nothing outstanding
//
// The AR path is combinational. The downstream slave must return read data
// in issue order, because routing relies purely on FIFO order.
// ---------------------------------------------------------------------------
module axi_lite_rd_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 32,
   parameter int OST_AW = 3
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              ifu_arvalid,
   output logic              ifu_arready,
   input  logic [ADDR_W-1:0] ifu_araddr,
   output logic              ifu_rvalid,
   input  logic              ifu_rready,
   output logic [1:0]        ifu_rresp,
   output logic [DATA_W-1:0] ifu_rdata,

   input  logic              lsu_arvalid,
   output logic              lsu_arready,
   input  logic [ADDR_W-1:0] lsu_araddr,
   output logic              lsu_rvalid,
   input  logic              lsu_rready,
   output logic [1:0]        lsu_rresp,
   output logic [DATA_W-1:0] lsu_rdata,

   output logic              m_arvalid,
   input  logic              m_arready,
   output logic [ADDR_W-1:0] m_araddr,
   input  logic              m_rvalid,
   output logic              m_rready,
   input  logic [1:0]        m_rresp,
   input  logic [DATA_W-1:0] m_rdata,

   output logic [OST_AW:0]   ost_cnt,
   output logic              rsp_err
);

   localparam int DEPTH = 1 << OST_AW;
   localparam logic [OST_AW:0] FULL_CNT = {1'b1, {OST_AW{1'b0}}};

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   owner_e              fifo_mem [DEPTH];
   logic [OST_AW-1:0]   wr_ptr;
   logic [OST_AW-1:0]   rd_ptr;
   logic                lock;
   owner_e              lock_owner;
   owner_e              last_grant;

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   logic                fifo_full;
   logic                fifo_empty;
   logic                sel_valid;
   owner_e              sel_id;
   owner_e              head_id;
   logic                ar_hs;
   logic                r_hs;
   logic                r_drop;

   assign fifo_full  = (ost_cnt == FULL_CNT);
   assign fifo_empty = (ost_cnt == '0);

   // ------------------------------------------------------------------------
   // AR arbitration
   // ------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first so no path leaves
   // it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      sel_valid = 1'b0;
      sel_id    = OWN_IFU;
      if (lock) begin
         // A stalled request must stay on the bus until it is accepted.
         sel_id    = lock_owner;
         sel_valid = (lock_owner == OWN_LSU) ? lsu_arvalid : ifu_arvalid;
      end else if (ifu_arvalid && lsu_arvalid) begin
         sel_valid = 1'b1;
         sel_id    = (last_grant == OWN_LSU) ? OWN_IFU : OWN_LSU;
      end else if (ifu_arvalid) begin
         sel_valid = 1'b1;
         sel_id    = OWN_IFU;
      end else if (lsu_arvalid) begin
         sel_valid = 1'b1;
         sel_id    = OWN_LSU;
      end
   end

   // A full FIFO blocks new addresses even when a pop happens this cycle;
   // the freed slot is usable from the next cycle on.
   assign m_arvalid   = sel_valid & ~fifo_full;
   assign m_araddr    = (sel_id == OWN_LSU) ? lsu_araddr : ifu_araddr;
   assign ifu_arready = m_arvalid & m_arready & (sel_id == OWN_IFU);
   assign lsu_arready = m_arvalid & m_arready & (sel_id == OWN_LSU);
   assign ar_hs       = m_arvalid & m_arready;

   // ------------------------------------------------------------------------
   // R routing
   // ------------------------------------------------------------------------
   assign head_id = fifo_mem[rd_ptr];

   always_comb begin
      ifu_rvalid = 1'b0;
      lsu_rvalid = 1'b0;
      m_rready   = 1'b0;
      if (fifo_empty) begin
         // Unexpected beat: accept and discard it so the slave cannot hang.
         m_rready = m_rvalid;
      end else if (head_id == OWN_IFU) begin
         ifu_rvalid = m_rvalid;
         m_rready   = ifu_rready;
      end else begin
         lsu_rvalid = m_rvalid;
         m_rready   = lsu_rready;
      end
   end

   // Payload is broadcast; only the routed master's rvalid qualifies it.
   assign ifu_rresp = m_rresp;
   assign ifu_rdata = m_rdata;
   assign lsu_rresp = m_rresp;
   assign lsu_rdata = m_rdata;

   assign r_hs   = m_rvalid & m_rready & ~fifo_empty;
   assign r_drop = m_rvalid & fifo_empty;

   // ------------------------------------------------------------------------
   // Owner FIFO storage
   // ------------------------------------------------------------------------
   // NOTE: the storage array has no reset; an entry is only read after it
   // has been written, and leaving it unreset lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (ar_hs) begin
         fifo_mem[wr_ptr] <= sel_id;
      end
   end

   // ------------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ost_cnt    <= '0;
         lock       <= 1'b0;
         lock_owner <= OWN_IFU;
         last_grant <= OWN_LSU;   // IFU wins the first tie after reset
         rsp_err    <= 1'b0;
      end else begin
         if (ar_hs) begin
            wr_ptr     <= wr_ptr + OST_AW'(1);
            last_grant <= sel_id;
         end
         if (r_hs) begin
            rd_ptr <= rd_ptr + OST_AW'(1);
         end

         case ({ar_hs, r_hs})
            2'b10:   ost_cnt <= ost_cnt + (OST_AW+1)'(1);
            2'b01:   ost_cnt <= ost_cnt - (OST_AW+1)'(1);
            default: ost_cnt <= ost_cnt;
         endcase

         if (ar_hs) begin
            lock <= 1'b0;
         end else if (m_arvalid) begin
            lock       <= 1'b1;
            lock_owner <= sel_id;
         end

         if (r_drop) begin
            rsp_err <= 1'b1;
         end
      end
   end

endmodule

// File: doc/axi_lite_rd_arbiter.md
Name: axi_lite_rd_arbiter

Overview:
- Shares one AXI-lite read port (memory/bus side) between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Round-robin arbitration on the AR channel; an in-order owner FIFO steers each R beat back to the master that issued it.
- Supports up to 2^OST_AW outstanding reads, which covers the IFU's 4-deep prefetch.
- Sits between the core's ifu/lsu AXI-lite masters and the single downstream slave.

Parameters:
- ADDR_W, 64, address width of all AR channels.
- DATA_W, 32, read data width of all R channels.
- OST_AW, 3, log2 of owner-FIFO depth (max outstanding reads = 8).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- ifu_arvalid  input  1  IFU read address valid.
- ifu_arready  output  1  IFU read address ready.
- ifu_araddr  input  ADDR_W  IFU read address.
- ifu_rvalid  output  1  IFU read data valid.
- ifu_rready  input  1  IFU read data ready.
- ifu_rresp  output  2  IFU read response.
- ifu_rdata  output  DATA_W  IFU read data.
- lsu_arvalid, lsu_arready, lsu_araddr, lsu_rvalid, lsu_rready, lsu_rresp, lsu_rdata: same widths/directions as ifu_*, for the LSU.
- m_arvalid  output  1  downstream address valid.
- m_arready  input  1  downstream address ready.
- m_araddr  output  ADDR_W  downstream address.
- m_rvalid  input  1  downstream data valid.
- m_rready  output  1  downstream data ready.
- m_rresp  input  2  downstream response.
- m_rdata  input  DATA_W  downstream data.
- ost_cnt  output  OST_AW+1  outstanding read count.
- rsp_err  output  1  sticky flag: an R beat arrived with no outstanding read.

Behaviour:
- Reset, asynchronous and active-low: owner FIFO empty, ost_cnt=0, lock=0, last_grant=LSU (so the IFU wins the first tie), rsp_err=0.
- After reset, with all inputs low, every valid/ready output is 0.
- AR path is combinational (zero-cycle): m_arvalid/m_araddr are driven from the selected master; only the selected master sees arready=m_arready.

Arbitration:
- If lock=1, select lock_owner.
- Else, if exactly one master has arvalid, select it.
- Else, if both have arvalid, select the master opposite last_grant.
- Else, no selection; m_arvalid=0.

AR gating and lock:
- Owner FIFO full (ost_cnt==2^OST_AW): m_arvalid=0 and both arready=0, even if a pop happens in the same cycle.
- Lock set, with lock_owner=selected, when m_arvalid & !m_arready. This keeps address stability; AXI forbids switching mid-request.
- Lock cleared on AR handshake.
- AR handshake (m_arvalid & m_arready): push the owner id into the FIFO; last_grant<=owner.

R routing:
- FIFO head selects the destination: head_rvalid=m_rvalid, other master rvalid=0, m_rready=head master's rready.
- rresp/rdata are broadcast to both masters; only the routed master's rvalid qualifies them.
- R handshake pops the FIFO.
- Push and pop in the same cycle: ost_cnt unchanged, pointers both advance.
- FIFO empty and m_rvalid=1: m_rready=1, beat dropped, both master rvalid=0, rsp_err<=1. rsp_err clears only on reset.

Ordering and flush:
- Responses return strictly in issue order; the downstream slave must be in-order.
- No flush input. A master's pipeline flush does not cancel outstanding reads; the master must still accept its beats (the IFU holds rready=1).
- Pointers are OST_AW bits and wrap naturally.
- ost_cnt = pushes − pops, range 0..2^OST_AW.

Test Plan:
- Single IFU read, m_arready=1, m_rvalid two cycles later with data 0x00000013 -> ifu_rvalid=1 with that data, lsu_rvalid=0, ost_cnt goes 0→1→0.
- Both masters assert arvalid every cycle from reset with m_arready=1 -> grants alternate IFU, LSU, IFU, LSU; R beats return in that same order to the matching master.
- LSU selected and m_arready=0 for 3 cycles while IFU arvalid rises -> m_araddr stays at the LSU address and ifu_arready=0 until the LSU handshake; the IFU is granted next.
- 8 IFU reads issued with no R beats -> ost_cnt=8, ifu_arready=0 and m_arvalid=0 on the 9th; one R pop -> the 9th AR is accepted the following cycle.
- Interleaved IFU/LSU reads, lsu_rready=0 for 2 cycles while the head is LSU -> m_rready=0, the IFU beat behind it is not delivered, no reordering.
- m_rvalid=1 with ost_cnt=0 -> m_rready=1, no master rvalid, rsp_err=1 and it stays 1 until rst_n low.
